serial_add_ctrl: RTL and testbench

Bit-serial addition controller that time-shares a single `full_adder` instance across all bits of a WIDTH-bit operand pair. It captures operands on a start request, feeds one bit per clock to the full adder LSB-first, and recirculates the carry through a register. It assembles the sum and reports completion with a one-cycle done pulse. It sits between a requesting unit and the existing `full_adder`, which it drives through dedicated `fa_*` ports.

---
 rtl/serial_add_ctrl.sv | 117 +++++++++++
 tb/tb_serial_add_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: time-shares one external full adder across
// WIDTH bits, LSB first, with the carry recirculated through a register.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout_out,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    input  logic             fa_sum,
    input  logic             fa_cout
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] sh_a_q, sh_a_d;
    logic [WIDTH-1:0] sh_b_q, sh_b_d;
    logic [WIDTH-1:0] sh_s_q, sh_s_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic [WIDTH-1:0] sh_s_next;

    // New sum bit enters at the MSB; written as a shift of the concatenation
    // so it stays legal when WIDTH is 1.
    assign sh_s_next = WIDTH'({fa_sum, sh_s_q} >> 1);

    always_comb begin
        // NOTE: every signal gets a default here so no path leaves one unassigned (no latches).
        state_d = state_q;
        sh_a_d  = sh_a_q;
        sh_b_d  = sh_b_q;
        sh_s_d  = sh_s_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        fa_a    = 1'b0;
        fa_b    = 1'b0;
        fa_cin  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sh_a_d  = a_in;
                    sh_b_d  = b_in;
                    carry_d = cin_in;
                    cnt_d   = '0;
                    sh_s_d  = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                fa_a    = sh_a_q[0];
                fa_b    = sh_b_q[0];
                fa_cin  = carry_q;
                sh_a_d  = sh_a_q >> 1;
                sh_b_d  = sh_b_q >> 1;
                sh_s_d  = sh_s_next;
                carry_d = fa_cout;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    sum_d   = sh_s_next;
                    cout_d  = fa_cout;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sh_a_q  <= '0;
            sh_b_q  <= '0;
            sh_s_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_a_q  <= sh_a_d;
            sh_b_q  <= sh_b_d;
            sh_s_q  <= sh_s_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);
    assign sum_out  = sum_q;
    assign cout_out = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl: a cycle-countdown reference model
// predicts busy/done/fa_* and queues expected sums; a negedge monitor checks.
module tb_serial_add_ctrl;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a_in, b_in;
    logic             cin_in;
    logic             busy, done;
    logic [WIDTH-1:0] sum_out;
    logic             cout_out;
    logic             fa_a, fa_b, fa_cin;
    logic             fa_sum, fa_cout;

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .a_in(a_in), .b_in(b_in), .cin_in(cin_in),
        .busy(busy), .done(done), .sum_out(sum_out), .cout_out(cout_out),
        .fa_a(fa_a), .fa_b(fa_b), .fa_cin(fa_cin),
        .fa_sum(fa_sum), .fa_cout(fa_cout)
    );

    // Behavioural full adder on the fa_* ports.
    assign {fa_cout, fa_sum} = 2'(fa_a) + 2'(fa_b) + 2'(fa_cin);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an accepted request keeps the unit busy for WIDTH+1 cycles,
    // the last of which is the done cycle.
    int               rem = 0;
    int               n_accept = 0;
    int               n_exp_done = 0;
    int               n_done = 0;
    logic [WIDTH:0]   exp_q[$];
    logic [WIDTH:0]   hold = '0;
    logic [WIDTH-1:0] cur_a = '0, cur_b = '0;
    logic             cur_cin = 1'b0;
    bit               mon_en = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            rem <= 0;
            hold <= '0;
            exp_q.delete();
        end else if (rem == 0) begin
            if (start) begin
                cur_a   <= a_in;
                cur_b   <= b_in;
                cur_cin <= cin_in;
                exp_q.push_back((WIDTH+1)'(a_in) + (WIDTH+1)'(b_in) + (WIDTH+1)'(cin_in));
                rem      <= WIDTH + 1;
                n_accept <= n_accept + 1;
            end
        end else begin
            rem <= rem - 1;
            if (rem == 2) begin
                hold       <= exp_q[0];
                n_exp_done <= n_exp_done + 1;
            end
        end
    end

    // Monitor: sample on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (mon_en) begin
            int bit_i, mask, partial;
            logic [2:0] exp_fa;
            logic [WIDTH:0] got;
            check("busy", busy, rem > 0);
            check("done", done, rem == 1);
            check("result_hold", {cout_out, sum_out}, hold);
            exp_fa = '0;
            if (rem >= 2) begin
                bit_i   = WIDTH + 1 - rem;
                mask    = (1 << bit_i) - 1;
                partial = (int'(cur_a) & mask) + (int'(cur_b) & mask) + int'(cur_cin);
                exp_fa  = {cur_a[bit_i], cur_b[bit_i], 1'((partial >> bit_i) & 1)};
            end
            check("fa_ports", {fa_a, fa_b, fa_cin}, exp_fa);
            if (done) begin
                n_done++;
                if (exp_q.size() == 0) begin
                    check("done_no_request", done, 1'b0);
                end else begin
                    got = exp_q.pop_front();
                    check("scoreboard", {cout_out, sum_out}, got);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive a request and hold start until the model accepts it; operands are
    // then scrambled to confirm they were captured.
    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin);
        int prev;
        prev   = n_accept;
        start  = 1'b1;
        a_in   = a;
        b_in   = b;
        cin_in = cin;
        for (int t = 0; t < 40 && n_accept == prev; t++) step(1);
        check("accept", n_accept, prev + 1);
        start  = 1'b0;
        a_in   = WIDTH'($urandom);
        b_in   = WIDTH'($urandom);
        cin_in = 1'($urandom);
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 40 && rem != 0; t++) step(1);
        check("idle_wait", rem, 0);
    endtask

    initial begin
        int prev, gap;
        rst_n  = 1'b0;
        start  = 1'b1;
        a_in   = WIDTH'($urandom);
        b_in   = WIDTH'($urandom);
        cin_in = 1'($urandom);

        // Reset held for two edges with start asserted.
        step(1);
        mon_en = 1'b1;
        step(1);
        check("rst_result", {cout_out, sum_out}, 0);
        check("rst_busy", busy, 0);
        check("rst_fa", {fa_a, fa_b, fa_cin}, 0);
        rst_n = 1'b1;
        start = 1'b0;
        step(1);

        issue(8'h3C, 8'h0F, 1'b1);
        check("t2_busy", busy, 1);
        wait_idle();
        check("t2_result", {cout_out, sum_out}, 9'h04C);

        issue(8'hFF, 8'h01, 1'b0);
        wait_idle();
        check("t3_result", {cout_out, sum_out}, 9'h100);

        // Second request held through RUN and DONE; taken only in the next IDLE.
        issue(8'h12, 8'h34, 1'b0);
        start  = 1'b1;
        a_in   = 8'hFF;
        b_in   = 8'hFF;
        cin_in = 1'b0;
        prev   = n_accept;
        gap    = 0;
        while (gap < 40 && n_accept == prev) begin
            step(1);
            gap++;
        end
        check("t4_gap", gap, WIDTH + 2);
        check("t4_first", {cout_out, sum_out}, 9'h046);
        start = 1'b0;
        wait_idle();
        check("t4_second", {cout_out, sum_out}, 9'h1FE);

        // Reset at the 4th RUN edge aborts the operation.
        issue(8'hAA, 8'h55, 1'b0);
        step(3);
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        check("t5_busy", busy, 0);
        check("t5_cleared", {cout_out, sum_out}, 0);
        step(2);
        issue(8'h01, 8'h01, 1'b1);
        wait_idle();
        check("t5_result", {cout_out, sum_out}, 9'h003);

        for (int n = 0; n < 1000; n++) begin
            issue(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
            wait_idle();
            step($urandom_range(0, 2));
        end

        step(2);
        check("done_count", n_done, n_exp_done);
        check("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
